param_cache: RTL and testbench

//  Parametrised direct-mapped, write-through, no-write-allocate cache between CPU and memory.

---
 rtl/param_cache_if.sv | 38 +++
 rtl/param_cache.sv | 188 ++++++++++++++++++
 tb/tb_param_cache.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/param_cache_if.sv
// Bus bundle between the parametrised cache and its CPU, memory and snoop agents.
// The slave view belongs to the cache; the master view belongs to the surrounding system.
interface param_cache_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 2
);
    localparam int MEM_W = DATA_W * LINE_WORDS;
    localparam int REQ_W = 1 + ADDR_W + DATA_W;

    logic [REQ_W-1:0]  cpu_request;
    logic              cpu_request_ready;
    logic              cpu_busy;
    logic [DATA_W-1:0] data_out;
    logic              data_out_ready;
    logic [REQ_W-1:0]  memory_request;
    logic              memory_request_ready;
    logic [MEM_W-1:0]  memory_response;
    logic              memory_response_ready;
    logic              invalidate_valid;
    logic [ADDR_W-1:0] invalidate_address;

    modport slave (
        input  cpu_request, cpu_request_ready,
        input  memory_response, memory_response_ready,
        input  invalidate_valid, invalidate_address,
        output cpu_busy, data_out, data_out_ready,
        output memory_request, memory_request_ready
    );

    modport master (
        output cpu_request, cpu_request_ready,
        output memory_response, memory_response_ready,
        output invalidate_valid, invalidate_address,
        input  cpu_busy, data_out, data_out_ready,
        input  memory_request, memory_request_ready
    );
endinterface

// File: rtl/param_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with snoop invalidation.
// A snoop that hits the line being fetched poisons the fill so stale data is never installed.
//
// state      | meaning
// S_IDLE     | ready for a CPU request, poison cleared
// S_LOOKUP   | tag/valid compare on the latched request
// S_MEM_REQ  | one-cycle memory request pulse
// S_MEM_WAIT | waiting for line data (read) or write ack
// S_FILL     | install fetched line, select requested word
// S_RESPOND  | one-cycle completion pulse to the CPU
module param_cache #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 2,
    parameter int SETS       = 16
) (
    input logic          clock,
    input logic          reset,
    param_cache_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int MEM_W = DATA_W * LINE_WORDS;
    localparam int REQ_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_FILL,
        S_RESPOND
    } state_t;

    state_t            state_q, state_d;
    logic [REQ_W-1:0]  req_q, req_d;
    logic [REQ_W-1:0]  mem_req_q, mem_req_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [MEM_W-1:0]  fill_q, fill_d;
    logic              poison_q, poison_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [MEM_W-1:0]  line_q [SETS];

    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  inv_idx;
    logic [TAG_W-1:0]  inv_tag;
    logic              hit;
    logic              inv_stored_hit;
    logic              inv_pending_hit;
    logic              wr_ack_hit;

    function automatic logic [DATA_W-1:0] word_sel(input logic [MEM_W-1:0] line,
                                                   input logic [OFF_W-1:0] off);
        word_sel = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (off == OFF_W'(w)) word_sel = line[w*DATA_W +: DATA_W];
        end
    endfunction

    function automatic logic [MEM_W-1:0] word_put(input logic [MEM_W-1:0]  line,
                                                  input logic [OFF_W-1:0]  off,
                                                  input logic [DATA_W-1:0] word);
        word_put = line;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (off == OFF_W'(w)) word_put[w*DATA_W +: DATA_W] = word;
        end
    endfunction

    assign req_wr    = req_q[REQ_W-1];
    assign req_addr  = req_q[DATA_W +: ADDR_W];
    assign req_wdata = req_q[DATA_W-1:0];
    assign req_off   = req_addr[OFF_W-1:0];
    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign inv_idx   = bus.invalidate_address[OFF_W +: IDX_W];
    assign inv_tag   = bus.invalidate_address[ADDR_W-1 -: TAG_W];

    // All compares use pre-edge valid/tag, so a same-cycle snoop never masks a lookup hit.
    assign hit             = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign inv_stored_hit  = bus.invalidate_valid && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
    assign inv_pending_hit = bus.invalidate_valid && (inv_idx == req_idx) && (inv_tag == req_tag);
    assign wr_ack_hit      = (state_q == S_MEM_WAIT) && bus.memory_response_ready && req_wr && hit;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        mem_req_d  = mem_req_q;
        data_out_d = data_out_q;
        fill_d     = fill_q;
        poison_d   = poison_q;
        valid_d    = valid_q;

        if (inv_stored_hit) valid_d[inv_idx] = 1'b0;

        case (state_q)
            S_IDLE: begin
                poison_d = 1'b0;
                if (bus.cpu_request_ready) begin
                    req_d   = bus.cpu_request;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!req_wr && hit) begin
                    data_out_d = word_sel(line_q[req_idx], req_off);
                    state_d    = S_RESPOND;
                end else begin
                    mem_req_d = req_wr ? req_q
                                       : {1'b0, req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}, {DATA_W{1'b0}}};
                    state_d   = S_MEM_REQ;
                end
            end
            S_MEM_REQ: state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (bus.memory_response_ready) begin
                    if (req_wr) begin
                        data_out_d = req_wdata;
                        state_d    = S_RESPOND;
                    end else begin
                        fill_d  = bus.memory_response;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                // Any snoop into the set being filled leaves it invalid, on top of earlier poison.
                valid_d[req_idx] = !(poison_q || (bus.invalidate_valid && (inv_idx == req_idx)));
                data_out_d       = word_sel(fill_q, req_off);
                state_d          = S_RESPOND;
            end
            S_RESPOND: begin
                poison_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!req_wr && inv_pending_hit &&
            ((state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT) || (state_q == S_FILL))) begin
            poison_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            mem_req_q  <= '0;
            data_out_q <= '0;
            fill_q     <= '0;
            poison_q   <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            mem_req_q  <= mem_req_d;
            data_out_q <= data_out_d;
            fill_q     <= fill_d;
            poison_q   <= poison_d;
            valid_q    <= valid_d;
        end
    end

    // Line and tag storage carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state_q == S_FILL) begin
                line_q[req_idx] <= fill_q;
                tag_q[req_idx]  <= req_tag;
            end else if (wr_ack_hit) begin
                line_q[req_idx] <= word_put(line_q[req_idx], req_off, req_wdata);
            end
        end
    end

    assign bus.cpu_busy             = (state_q != S_IDLE);
    assign bus.data_out             = data_out_q;
    assign bus.data_out_ready       = (state_q == S_RESPOND);
    assign bus.memory_request       = mem_req_q;
    assign bus.memory_request_ready = (state_q == S_MEM_REQ);
endmodule

// File: tb/tb_param_cache.sv
// Self-checking bench for param_cache: directed scenarios followed by random traffic,
// compared against a behavioural cache/memory model held in plain arrays.
module tb_param_cache;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int LINE_WORDS = 2;
    localparam int SETS       = 16;
    localparam int MEM_W      = DATA_W * LINE_WORDS;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    param_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) bus ();

    param_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] bmem   [65536];
    bit         mvalid [SETS];
    int         mtag   [SETS];
    logic [7:0] mdata  [SETS][LINE_WORDS];
    bit         poison;
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic int idx_of(input int a); return (a / LINE_WORDS) % SETS; endfunction
    function automatic int tag_of(input int a); return a / (LINE_WORDS * SETS); endfunction
    function automatic int off_of(input int a); return a % LINE_WORDS; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_inv(input int a, input bit pend_read, input int pend_addr);
        if (mvalid[idx_of(a)] && mtag[idx_of(a)] == tag_of(a)) mvalid[idx_of(a)] = 1'b0;
        if (pend_read && (a / LINE_WORDS) == (pend_addr / LINE_WORDS)) poison = 1'b1;
    endtask

    task automatic inv_idle(input int a);
        bus.invalidate_valid   = 1'b1;
        bus.invalidate_address = 16'(a);
        tick();
        bus.invalidate_valid = 1'b0;
        model_inv(a, 1'b0, 0);
        check("inv_idle_busy", bus.cpu_busy, 0);
    endtask

    // inv_mode: 0 none, 1 snoop on the lookup edge, 2 snoop during memory wait
    task automatic access(input bit wr, input int addr, input logic [7:0] wd,
                          input int inv_mode, input int inv_addr, input bit stray);
        bit               exp_hit;
        int               idx, off, base, waits;
        logic [24:0]      exp_mreq;
        logic [7:0]       exp_data;
        logic [MEM_W-1:0] line;
        idx     = idx_of(addr);
        off     = off_of(addr);
        base    = addr - off;
        exp_hit = !wr && mvalid[idx] && mtag[idx] == tag_of(addr);
        exp_data = exp_hit ? mdata[idx][off] : 8'h00;
        poison  = 1'b0;

        bus.cpu_request       = {wr, 16'(addr), wd};
        bus.cpu_request_ready = 1'b1;
        tick();
        bus.cpu_request_ready = 1'b0;
        check("busy_lookup", bus.cpu_busy, 1);
        if (stray) begin
            bus.cpu_request       = {1'b1, 16'(addr ^ 32'h0100), 8'hA5};
            bus.cpu_request_ready = 1'b1;
        end
        if (inv_mode == 1) begin
            bus.invalidate_valid   = 1'b1;
            bus.invalidate_address = 16'(inv_addr);
        end
        tick();
        bus.cpu_request_ready = 1'b0;
        bus.invalidate_valid  = 1'b0;
        if (inv_mode == 1) model_inv(inv_addr, 1'b0, addr);

        if (exp_hit) begin
            check("hit_ready", bus.data_out_ready, 1);
            check("hit_data", bus.data_out, exp_data);
            check("hit_no_memreq", bus.memory_request_ready, 0);
        end else begin
            exp_mreq = wr ? {1'b1, 16'(addr), wd} : {1'b0, 16'(base), 8'h00};
            check("memreq_pulse", bus.memory_request_ready, 1);
            check("memreq", bus.memory_request, exp_mreq);
            check("miss_no_ready", bus.data_out_ready, 0);
            tick();
            check("memreq_one_cycle", bus.memory_request_ready, 0);
            check("memreq_held", bus.memory_request, exp_mreq);
            waits = $urandom_range(0, 3);
            if (inv_mode == 2 && waits == 0) waits = 1;
            for (int w = 0; w < waits; w++) begin
                if (inv_mode == 2 && w == 0) begin
                    bus.invalidate_valid   = 1'b1;
                    bus.invalidate_address = 16'(inv_addr);
                end
                tick();
                bus.invalidate_valid = 1'b0;
                if (inv_mode == 2 && w == 0) model_inv(inv_addr, !wr, addr);
                check("wait_no_ready", bus.data_out_ready, 0);
            end
            for (int k = 0; k < LINE_WORDS; k++) line[k*DATA_W +: DATA_W] = bmem[base + k];
            bus.memory_response       = wr ? MEM_W'($urandom) : line;
            bus.memory_response_ready = 1'b1;
            tick();
            bus.memory_response_ready = 1'b0;
            bus.memory_response       = MEM_W'($urandom);
            if (wr) begin
                bmem[addr] = wd;
                if (mvalid[idx] && mtag[idx] == tag_of(addr)) mdata[idx][off] = wd;
                exp_data = wd;
            end else begin
                check("fill_no_ready", bus.data_out_ready, 0);
                tick();
                for (int k = 0; k < LINE_WORDS; k++) mdata[idx][k] = bmem[base + k];
                mtag[idx]   = tag_of(addr);
                mvalid[idx] = !poison;
                exp_data    = bmem[addr];
            end
            check("resp_ready", bus.data_out_ready, 1);
            check("resp_data", bus.data_out, exp_data);
        end
        tick();
        check("done_ready_low", bus.data_out_ready, 0);
        check("done_idle", bus.cpu_busy, 0);
        if (stray) begin
            tick();
            check("stray_dropped", bus.cpu_busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, r, mode, ia;
        bus.cpu_request           = '0;
        bus.cpu_request_ready     = 1'b0;
        bus.memory_response       = '0;
        bus.memory_response_ready = 1'b0;
        bus.invalidate_valid      = 1'b0;
        bus.invalidate_address    = '0;
        for (int i = 0; i < 65536; i++) bmem[i] = 8'($urandom);
        for (int s = 0; s < SETS; s++) mvalid[s] = 1'b0;
        bmem[16'h1234] = 8'hEF;
        bmem[16'h1235] = 8'hBE;

        reset = 1'b0;
        tick(); tick(); tick();
        check("rst_busy", bus.cpu_busy, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_data_out_ready", bus.data_out_ready, 0);
        check("rst_memreq", bus.memory_request, 0);
        check("rst_memreq_ready", bus.memory_request_ready, 0);
        reset = 1'b1;
        tick();

        // Scenarios 1-3: miss fill, neighbour hit, write-through then hit
        access(1'b0, 16'h1234, 8'h00, 0, 0, 1'b0);
        access(1'b0, 16'h1235, 8'h00, 0, 0, 1'b0);
        access(1'b1, 16'h1235, 8'h5A, 0, 0, 1'b0);
        access(1'b0, 16'h1235, 8'h00, 0, 0, 1'b0);

        // Scenario 4: snoop, eviction by a same-index line, re-miss
        inv_idle(16'h1234);
        access(1'b0, 16'h1235, 8'h00, 0, 0, 1'b0);
        access(1'b0, 16'h1254, 8'h00, 0, 0, 1'b0);
        access(1'b0, 16'h1234, 8'h00, 0, 0, 1'b0);
        access(1'b0, 16'h1234, 8'h00, 1, 16'h1234, 1'b0);

        // Scenario 5: poisoned fill still answers, re-read misses, busy strobe dropped
        bmem[16'h1234] = 8'hEF;
        access(1'b0, 16'h1234, 8'h00, 2, 16'h1234, 1'b1);
        access(1'b0, 16'h1234, 8'h00, 0, 0, 1'b0);

        // Scenario 6: reset while waiting for memory
        inv_idle(16'h4000);
        bus.cpu_request       = {1'b0, 16'h4000, 8'h00};
        bus.cpu_request_ready = 1'b1;
        tick();
        bus.cpu_request_ready = 1'b0;
        tick();
        check("rst6_memreq_pulse", bus.memory_request_ready, 1);
        tick();
        reset = 1'b0;
        tick();
        check("rst6_busy", bus.cpu_busy, 0);
        check("rst6_data_out", bus.data_out, 0);
        check("rst6_data_out_ready", bus.data_out_ready, 0);
        check("rst6_memreq", bus.memory_request, 0);
        check("rst6_memreq_ready", bus.memory_request_ready, 0);
        reset = 1'b1;
        for (int s = 0; s < SETS; s++) mvalid[s] = 1'b0;
        bus.memory_response       = 16'h1357;
        bus.memory_response_ready = 1'b1;
        tick();
        bus.memory_response_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("rst6_late_ready", bus.data_out_ready, 0);
            check("rst6_late_busy", bus.cpu_busy, 0);
            tick();
        end
        access(1'b0, 16'h1234, 8'h00, 0, 0, 1'b0);

        // Random traffic over four tags so hits, evictions and snoops collide
        for (int i = 0; i < 120; i++) begin
            a    = ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
            r    = $urandom_range(0, 9);
            mode = $urandom_range(0, 5);
            ia   = ($urandom_range(0, 1) == 1) ? a : (($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
            if (r == 0) inv_idle(a);
            else if (r == 1) bmem[a] = 8'($urandom);
            else access(r < 4, a, 8'($urandom), (mode < 3) ? mode : 0, ia, ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
